// File: rtl/spi_adc_scheduler.sv
// Periodic multi-channel ADC scan scheduler driving an external SPI controller.
// Optional watchdog on the SPI response enabled with `define SPI_ADC_SCHED_TIMEOUT_EN.
module spi_adc_scheduler #(
    parameter int NUM_CHANNELS   = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int SAMPLE_PERIOD  = 2000,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            enable_in,
    input  logic [NUM_CHANNELS-1:0]         channel_mask_in,
    output logic                            spi_trigger_out,
    output logic [DATA_WIDTH-1:0]           spi_data_out,
    input  logic [DATA_WIDTH-1:0]           spi_data_in,
    input  logic                            spi_valid_in,
    output logic [DATA_WIDTH-1:0]           sample_out,
    output logic [$clog2(NUM_CHANNELS)-1:0] sample_channel_out,
    output logic                            sample_valid_out,
    output logic                            frame_done_out,
    output logic                            overrun_out,
    output logic                            timeout_out
);

    localparam int CW = $clog2(NUM_CHANNELS);
    localparam int PW = $clog2(SAMPLE_PERIOD);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_TICK  = 3'd1,
        ISSUE      = 3'd2,
        WAIT_VALID = 3'd3,
        NEXT       = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [PW-1:0]           cnt_q, cnt_d;
    logic [NUM_CHANNELS-1:0] mask_q, mask_d;
    logic [CW-1:0]           ch_q, ch_d;
    logic [DATA_WIDTH-1:0]   cmd_q, cmd_d;
    logic                    stop_q, stop_d;
    logic [DATA_WIDTH-1:0]   sample_q, sample_d;
    logic [CW-1:0]           sample_ch_q, sample_ch_d;
    logic                    sample_valid_q, sample_valid_d;
    logic                    frame_done_q, frame_done_d;
    logic                    overrun_q, overrun_d;
    logic                    tick;
    logic                    busy;
    logic [NUM_CHANNELS-1:0] remaining;

`ifdef SPI_ADC_SCHED_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WW-1:0] wd_q, wd_d;
    logic          timeout_q, timeout_d;
`endif

    function automatic logic [CW-1:0] lowest_set(input logic [NUM_CHANNELS-1:0] m);
        lowest_set = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = CW'(i);
        end
    endfunction

    function automatic logic [DATA_WIDTH-1:0] cmd_word(input logic [CW-1:0] ch);
        cmd_word = '0;
        cmd_word[DATA_WIDTH-1] = 1'b1;
        cmd_word[DATA_WIDTH-2 -: CW] = ch;
    endfunction

    assign tick      = (cnt_q == '0) && enable_in;
    assign busy      = (state_q == ISSUE) || (state_q == WAIT_VALID) || (state_q == NEXT);
    assign remaining = mask_q & ~(NUM_CHANNELS'(1) << ch_q);

    always_comb begin
        state_d        = state_q;
        mask_d         = mask_q;
        ch_d           = ch_q;
        cmd_d          = cmd_q;
        stop_d         = stop_q;
        sample_d       = sample_q;
        sample_ch_d    = sample_ch_q;
        sample_valid_d = 1'b0;
        frame_done_d   = 1'b0;
        overrun_d      = 1'b0;
`ifdef SPI_ADC_SCHED_TIMEOUT_EN
        wd_d           = wd_q;
        timeout_d      = 1'b0;
`endif

        unique case (state_q)
            // IDLE treats the first enabled cycle as a tick, so it shares the frame start.
            IDLE, WAIT_TICK: begin
                stop_d = 1'b0;
                if (!enable_in) begin
                    state_d = IDLE;
                end else if (tick) begin
                    mask_d = channel_mask_in;
                    if (channel_mask_in == '0) begin
                        frame_done_d = 1'b1;
                        state_d      = WAIT_TICK;
                    end else begin
                        ch_d    = lowest_set(channel_mask_in);
                        cmd_d   = cmd_word(lowest_set(channel_mask_in));
                        state_d = ISSUE;
                    end
                end else begin
                    state_d = WAIT_TICK;
                end
            end
            ISSUE: begin
                state_d = WAIT_VALID;
`ifdef SPI_ADC_SCHED_TIMEOUT_EN
                wd_d    = '0;
`endif
            end
            WAIT_VALID: begin
                if (spi_valid_in) begin
                    sample_d       = spi_data_in;
                    sample_ch_d    = ch_q;
                    sample_valid_d = 1'b1;
                    state_d        = NEXT;
`ifdef SPI_ADC_SCHED_TIMEOUT_EN
                end else if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = NEXT;
                end else begin
                    wd_d = wd_q + 1'b1;
`endif
                end
            end
            NEXT: begin
                mask_d = remaining;
                if (stop_q || !enable_in) begin
                    state_d = IDLE;
                end else if (remaining != '0) begin
                    ch_d    = lowest_set(remaining);
                    cmd_d   = cmd_word(lowest_set(remaining));
                    state_d = ISSUE;
                end else begin
                    frame_done_d = 1'b1;
                    state_d      = WAIT_TICK;
                end
            end
            default: state_d = IDLE;
        endcase

        if (busy && tick) overrun_d = 1'b1;
        // A disable seen mid-frame is remembered so the frame ends after the current sample.
        if (busy && !enable_in) stop_d = 1'b1;

        if (state_d == IDLE) begin
            cnt_d = '0;
        end else if (cnt_q == PW'(SAMPLE_PERIOD - 1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            mask_q         <= '0;
            ch_q           <= '0;
            cmd_q          <= '0;
            stop_q         <= 1'b0;
            sample_q       <= '0;
            sample_ch_q    <= '0;
            sample_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mask_q         <= mask_d;
            ch_q           <= ch_d;
            cmd_q          <= cmd_d;
            stop_q         <= stop_d;
            sample_q       <= sample_d;
            sample_ch_q    <= sample_ch_d;
            sample_valid_q <= sample_valid_d;
            frame_done_q   <= frame_done_d;
            overrun_q      <= overrun_d;
        end
    end

`ifdef SPI_ADC_SCHED_TIMEOUT_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_out = timeout_q;
`else
    assign timeout_out = 1'b0;
`endif

    assign spi_trigger_out    = (state_q == ISSUE);
    assign spi_data_out       = cmd_q;
    assign sample_out         = sample_q;
    assign sample_channel_out = sample_ch_q;
    assign sample_valid_out   = sample_valid_q;
    assign frame_done_out     = frame_done_q;
    assign overrun_out        = overrun_q;

endmodule
